rsa_decryptor: RTL and testbench
================================

# rsa_decryptor

Sequential RSA decryption engine that turns one DATA_W-bit ciphertext block into its plaintext block, m = c^d mod N. It is the receive-side counterpart of the combinational per-block encryption array and uses the same block width and key width. It replaces wide combinational exponentiation with one shared interleaved modular multiplier driven by a left-to-right square-and-multiply FSM. Blocks enter and leave through valid/ready handshakes.

## Interface
- DATA_W, 14, ciphertext/plaintext block width
- KEY_W, 32, width of modulus N and private exponent d; also the multiplier iteration count
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  ciphertext block and key present
- in_ready  out  1  engine idle, can accept a block
- cipher  in  DATA_W  ciphertext block c
- N  in  KEY_W  modulus
- d  in  KEY_W  private exponent
- out_valid  out  1  plaintext available
- out_ready  in  1  consumer accepts plaintext
- plain  out  DATA_W  plaintext block m

## Operation
- States: IDLE, REDUCE, SQR, MUL, DONE.
- IDLE: in_ready=1. The accept edge is in_valid&&in_ready. On that edge:
  - Latch cipher (zero-extended to KEY_W), N and d.
  - Set result=1 and bit index=KEY_W-1.
  - Go to REDUCE. If N<2, go straight to DONE with result=0.
- modmul(A,B), with A<N:
  - Iterates over B from MSB to LSB, one bit per cycle, for KEY_W cycles.
  - Each cycle: acc = 2·acc + (b_j ? A : 0), then subtract N up to twice so that acc<N.
  - Internal width is KEY_W+2. acc clears at the start of each modmul.
- REDUCE: base = modmul(1, c), which gives c mod N. Then go to SQR.
- SQR: result = modmul(result, result). Then go to MUL.
- MUL: tmp = modmul(result, base). Latch tmp into result only if d[bit]=1.
  - If bit==0, go to DONE. Otherwise decrement bit and go to SQR.
- DONE: out_valid=1 and plain=result[DATA_W-1:0], held stable until out_ready is sampled high. Then go to IDLE.
- in_ready=0 in every state except IDLE. Inputs are ignored while busy. Key changes take effect only on the next accept.
- d=0 gives result 1 when N≥2.
- Callers must keep N ≤ 2^DATA_W. Larger N silently truncates the plaintext.

## Timing
- Reset values: in_ready=0 while rst_n is low and 1 from the first edge after release; out_valid=0; plain=0; state IDLE; all datapath registers 0.
- Reset asserted mid-operation aborts immediately. No output is produced for the aborted block.
- Latency is counted from the accept edge to the edge that raises out_valid:
  - With CONFIG (const-time): L = KEY_W·(2·KEY_W+1), which is 2080 for KEY_W=32.
  - N<2: L=1.
- DONE with out_ready=1 returns to IDLE on the next edge. in_ready rises in the following cycle.
- Back-to-back accepts are spaced by at least L+2 cycles.
- out_valid never drops without a handshake. plain does not change while out_valid=1.

## Configuration
- RSA_DEC_CONST_TIME_EN defined:
  - MUL executes for every exponent bit.
  - Latency is independent of d, which prevents timing side-channels.
- Macro undefined:
  - MUL is skipped for zero bits: SQR goes directly to the next bit, or to DONE after bit 0.
  - L = KEY_W·(KEY_W+1+popcount(d)).
  - Results are identical in both modes.

## Test plan
- Known vector, KEY_W=32 (N=3233, d=2753, cipher=2790):
  - plain=65 in both modes.
  - L=2080 with RSA_DEC_CONST_TIME_EN defined.
  - L=1216 with it undefined (popcount(d)=5).
- Round-trip with the encryption array using N=3233, e=17: every m in {0, 1, 2, 65, 3232} returns the original m.
- Edge keys:
  - d=0, N=3233, c=1234: plain=1.
  - N=1: plain=0 with L=1.
  - cipher=0: plain=0.
- Backpressure: hold out_ready=0 for 50 cycles after out_valid.
  - plain stays stable and in_ready stays 0.
  - A new in_valid during this window is not accepted.
- Reset abort: pulse rst_n low at cycle 500 of a decryption.
  - Outputs return to reset values and out_valid never pulses.
  - A fresh block accepted after reset decrypts correctly.
- Input isolation: change cipher, N and d every cycle while busy. The result equals the value computed from the inputs latched at accept.

Source files
------------

// File: rtl/rsa_decryptor.sv
// Sequential RSA decryptor: m = c^d mod N using one interleaved modular multiplier
// under a left-to-right square-and-multiply FSM. Define RSA_DEC_CONST_TIME_EN for constant-time MUL.
module rsa_decryptor #(
  parameter int DATA_W = 14,
  parameter int KEY_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] cipher,
  input  logic [KEY_W-1:0]  N,
  input  logic [KEY_W-1:0]  d,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] plain
);

  localparam int CW = $clog2(KEY_W);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    REDUCE = 3'd1,
    SQR    = 3'd2,
    MUL    = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t            state_r, state_s;
  logic [KEY_W-1:0]  c_r, n_r, d_r, base_r, result_r, acc_r;
  logic [KEY_W-1:0]  result_s, base_s;
  logic [CW-1:0]     mm_cnt_r, e_idx_r;
  logic [KEY_W-1:0]  mm_a_s, mm_b_s, mm_red_s;
  logic [KEY_W+1:0]  mm_sum_s, mm_sub1_s, n_ext_s;
  logic              mm_last_s, accept_s, rise_s, e_dec_s, n_small_s;
  logic              in_ready_r, out_valid_r;
  logic [DATA_W-1:0] plain_r;

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign plain     = plain_r;

  assign accept_s  = in_valid && in_ready_r && (state_r == IDLE);
  assign n_small_s = (N < KEY_W'(2));
  assign mm_last_s = (mm_cnt_r == CW'(0));
  assign n_ext_s   = {2'b00, n_r};

  // Multiplier operand selection per phase
  always_comb begin
    mm_a_s = result_r;
    mm_b_s = result_r;
    case (state_r)
      REDUCE: begin
        mm_a_s = KEY_W'(1);
        mm_b_s = c_r;
      end
      MUL:     mm_b_s = base_r;
      default: mm_b_s = result_r;
    endcase
  end

  // One interleaved step: acc = 2*acc + b_j*A, then at most two conditional subtractions of N
  always_comb begin
    mm_sum_s  = {1'b0, acc_r, 1'b0} + (mm_b_s[mm_cnt_r] ? {2'b00, mm_a_s} : {(KEY_W+2){1'b0}});
    mm_sub1_s = (mm_sum_s >= n_ext_s) ? (mm_sum_s - n_ext_s) : mm_sum_s;
    mm_red_s  = (mm_sub1_s >= n_ext_s) ? KEY_W'(mm_sub1_s - n_ext_s) : KEY_W'(mm_sub1_s);
  end

  // Next-state and exponent-walk decisions
  always_comb begin
    state_s  = state_r;
    result_s = result_r;
    base_s   = base_r;
    e_dec_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_s  = n_small_s ? DONE : REDUCE;
          result_s = n_small_s ? {KEY_W{1'b0}} : KEY_W'(1);
        end else begin
          state_s = IDLE;
        end
      end
      REDUCE: begin
        base_s  = mm_last_s ? mm_red_s : base_r;
        state_s = mm_last_s ? SQR : REDUCE;
      end
      SQR: begin
        if (mm_last_s) begin
          result_s = mm_red_s;
`ifdef RSA_DEC_CONST_TIME_EN
          state_s = MUL;
`else
          // Zero exponent bits skip the multiply pass entirely
          if (d_r[e_idx_r]) begin
            state_s = MUL;
          end else if (e_idx_r == CW'(0)) begin
            state_s = DONE;
          end else begin
            state_s = SQR;
            e_dec_s = 1'b1;
          end
`endif
        end else begin
          state_s = SQR;
        end
      end
      MUL: begin
        if (mm_last_s) begin
          result_s = d_r[e_idx_r] ? mm_red_s : result_r;
          if (e_idx_r == CW'(0)) begin
            state_s = DONE;
          end else begin
            state_s = SQR;
            e_dec_s = 1'b1;
          end
        end else begin
          state_s = MUL;
        end
      end
      DONE:    state_s = (out_valid_r && out_ready) ? IDLE : DONE;
      default: state_s = IDLE;
    endcase
    // N<2 lands in DONE straight from IDLE, so out_valid is raised one edge later
    rise_s = (state_s == DONE) && !out_valid_r && (state_r != IDLE);
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Datapath, operand latches and multiplier iteration
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_r      <= {KEY_W{1'b0}};
      n_r      <= {KEY_W{1'b0}};
      d_r      <= {KEY_W{1'b0}};
      base_r   <= {KEY_W{1'b0}};
      result_r <= {KEY_W{1'b0}};
      acc_r    <= {KEY_W{1'b0}};
      mm_cnt_r <= {CW{1'b0}};
      e_idx_r  <= {CW{1'b0}};
    end else begin
      result_r <= result_s;
      base_r   <= base_s;
      if (accept_s) begin
        c_r      <= KEY_W'(cipher);
        n_r      <= N;
        d_r      <= d;
        acc_r    <= {KEY_W{1'b0}};
        mm_cnt_r <= CW'(KEY_W - 1);
        e_idx_r  <= CW'(KEY_W - 1);
      end else if (state_r inside {REDUCE, SQR, MUL}) begin
        acc_r    <= mm_last_s ? {KEY_W{1'b0}} : mm_red_s;
        mm_cnt_r <= mm_last_s ? CW'(KEY_W - 1) : (mm_cnt_r - CW'(1));
        e_idx_r  <= e_dec_s ? (e_idx_r - CW'(1)) : e_idx_r;
      end
    end
  end

  // Handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      plain_r     <= {DATA_W{1'b0}};
    end else begin
      in_ready_r <= (state_r == IDLE) && (state_s == IDLE);
      if (rise_s) begin
        out_valid_r <= 1'b1;
        plain_r     <= result_s[DATA_W-1:0];
      end else if ((state_r == DONE) && out_valid_r && out_ready) begin
        out_valid_r <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rsa_decryptor.sv
// Randomised self-checking bench for rsa_decryptor against a plain-arithmetic modexp model.
module tb_rsa_decryptor;

  logic        clk, rst_n, in_valid, in_ready, out_valid, out_ready;
  logic [13:0] cipher, plain;
  logic [31:0] N, d;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  logic        prev_ov = 1'b0;
  logic [13:0] prev_plain = '0;
  logic [13:0] exp_q[$];
  int          lat_q[$];
  int          acc_q[$];
  logic        scramble = 1'b0;

  rsa_decryptor #(.DATA_W(14), .KEY_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .cipher(cipher), .N(N), .d(d), .out_valid(out_valid),
    .out_ready(out_ready), .plain(plain)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic longint unsigned modexp(input longint unsigned c, input logic [31:0] e,
                                             input longint unsigned n);
    longint unsigned r, b;
    if (n < 2) return 0;
    r = 1;
    b = c % n;
    for (int i = 31; i >= 0; i--) begin
      r = (r * r) % n;
      if (e[i]) r = (r * b) % n;
    end
    return r;
  endfunction

  function automatic logic [13:0] model(input logic [13:0] c, input logic [31:0] e,
                                        input logic [31:0] n);
    longint unsigned r;
    r = modexp(longint'(c), e, longint'(n));
    return r[13:0];
  endfunction

  function automatic int lat(input logic [31:0] n, input logic [31:0] e);
    if (n < 2) return 1;
`ifdef RSA_DEC_CONST_TIME_EN
    return 32 * 65;
`else
    return 32 * (33 + $countones(e));
`endif
  endfunction

  // Scoreboard bookkeeping at the active edge (values sampled before the DUT updates)
  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      exp_q.delete(); lat_q.delete(); acc_q.delete();
    end else begin
      if (out_valid && out_ready && exp_q.size() > 0) begin
        void'(exp_q.pop_front()); void'(lat_q.pop_front()); void'(acc_q.pop_front());
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(cipher, d, N));
        lat_q.push_back(lat(N, d));
        acc_q.push_back(cyc);
      end
    end
  end

  // Output checks on the falling edge
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_plain", plain, 0);
    end else if (out_valid && !prev_ov) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_out_valid", 1, 0);
      end else begin
        chk("plain", plain, exp_q[0]);
        chk("latency", cyc - acc_q[0], lat_q[0]);
      end
    end else if (out_valid) begin
      chk("plain_stable", plain, prev_plain);
      chk("in_ready_busy", in_ready, 0);
    end
    prev_ov    = out_valid;
    prev_plain = plain;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic run(input logic [13:0] c, input logic [31:0] n, input logic [31:0] e,
                     input int hold, input logic scr);
    int k;
    k = 0;
    while (!in_ready && k < 200) begin tick(); k++; end
    chk("in_ready_timeout", in_ready, 1);
    cipher = c; N = n; d = e; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    k = 0;
    while (!out_valid && k < 5000) begin
      if (scr) begin
        cipher = 14'($urandom); N = $urandom; d = $urandom;
      end
      tick();
      k++;
    end
    chk("done_timeout", out_valid, 1);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1; cipher = 14'($urandom); N = $urandom_range(2, 16384); d = $urandom;
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  int ms[5] = '{0, 1, 2, 65, 3232};

  initial begin
    longint unsigned ct;
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0; cipher = '0; N = '0; d = '0;
    #1 rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("in_ready_before_edge", in_ready, 0);
    @(negedge clk);
    chk("in_ready_after_edge", in_ready, 1);

    // Pin the model with hand-computed values
    chk("model_known", model(14'd2790, 32'd2753, 32'd3233), 65);
    chk("model_d0", model(14'd1234, 32'd0, 32'd3233), 1);
    chk("model_n1", model(14'd5, 32'd77, 32'd1), 0);
`ifdef RSA_DEC_CONST_TIME_EN
    chk("lat_known", lat(32'd3233, 32'd2753), 2080);
`else
    chk("lat_known", lat(32'd3233, 32'd2753), 1216);
`endif
    chk("lat_n1", lat(32'd1, 32'd77), 1);

    run(14'd2790, 32'd3233, 32'd2753, 0, 1'b0);

    foreach (ms[i]) begin
      ct = modexp(longint'(ms[i]), 32'd17, 3233);
      chk("roundtrip_model", model(14'(ct), 32'd2753, 32'd3233), ms[i]);
      run(14'(ct), 32'd3233, 32'd2753, 0, 1'b0);
    end

    run(14'd1234, 32'd3233, 32'd0, 0, 1'b0);
    run(14'd5, 32'd1, 32'd77, 0, 1'b0);
    run(14'd0, 32'd3233, 32'd2753, 0, 1'b0);

    run(14'd2790, 32'd3233, 32'd2753, 50, 1'b0);

    // Abort mid-operation, then decrypt a fresh block
    while (!in_ready) tick();
    cipher = 14'd2790; N = 32'd3233; d = 32'd2753; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (500) tick();
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (100) tick();
    chk("abort_no_valid", out_valid, 0);
    run(14'd1000, 32'd3233, 32'd2753, 0, 1'b0);

    run(14'd2790, 32'd3233, 32'd2753, 0, 1'b1);

    for (int i = 0; i < 8; i++) begin
      run(14'($urandom), $urandom_range(2, 16384), $urandom, 0, 1'b0);
    end

    repeat (5) tick();
    chk("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
